mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder: req/ready handshake with fixed wait states.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LAST =
    4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            bad_q;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   idx;
  logic            oob;
  logic            bad;
  logic            commit;

  assign idx = addr[AW+1:2];
  assign oob = (addr >> (AW + 2)) != 32'd0;

`ifdef MEM_ALIGN_CHECK_EN
  assign bad = oob | (addr[1:0] != 2'b00);
`else
  logic unused;
  assign unused = ^addr[1:0];
  assign bad = oob;
`endif

  assign commit = (state == RESP) && we_q && !bad_q;

  // Handshake FSM: capture request, count wait states, register response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      bad_q   <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            idx_q   <= idx;
            wdata_q <= wdata;
            be_q    <= be;
            bad_q   <= bad;
            cnt     <= 4'd0;
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          ready <= 1'b1;
          err   <= bad_q;
          rdata <= (bad_q || we_q) ? 32'd0 : mem[idx_q];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage survives reset; writes land on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
